// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: word width, NOP encoding and PC step.
package mips_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t NOP_INSTR = 32'h0000_0000;
    localparam word_t PC_STEP   = 32'd4;

    // Force a fetch address onto a word boundary.
    function automatic word_t word_align(input word_t addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, otherwise load the fetched word.
module if_id_reg
    import mips_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  flush,
    input  logic  stall,
    input  word_t instr_in,
    input  word_t pc4_in,
    output word_t instr,
    output word_t pc4,
    output logic  valid
);

    word_t instr_reg;
    word_t pc4_reg;
    logic  valid_reg;

    // Squash to a NOP bubble on flush, hold on stall, else capture the new fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_reg <= NOP_INSTR;
            pc4_reg   <= '0;
            valid_reg <= 1'b0;
        end else if (flush) begin
            instr_reg <= NOP_INSTR;
            pc4_reg   <= '0;
            valid_reg <= 1'b0;
        end else if (!stall) begin
            instr_reg <= instr_in;
            pc4_reg   <= pc4_in;
            valid_reg <= 1'b1;
        end
    end

    assign instr = instr_reg;
    assign pc4   = pc4_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID register and fetch counters.
module if_stage
    import mips_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  stall,
    input  logic  flush,
    input  logic  branch_taken,
    input  word_t branch_target,
    input  logic  jump,
    input  word_t jump_target,
    input  word_t imem_rdata,
    output word_t imem_addr,
    output word_t pc,
    output word_t if_id_pc4,
    output word_t if_id_instr,
    output logic  if_id_valid,
    output word_t fetch_count,
    output logic  misaligned
);

    word_t pc_reg;
    word_t pc_next;
    word_t pc4;
    word_t redirect_target;
    logic  redirect;
    logic  flush_eff;
    logic  accept_fetch;
    word_t fetch_count_reg;
    logic  misaligned_reg;

    assign pc4       = pc_reg + PC_STEP;
    // A stalled ID stage re-resolves its branch next cycle, so redirects are ignored under stall.
    assign redirect  = (jump | branch_taken) & ~stall;
    // The instruction fetched alongside an accepted redirect is wrong-path and must be dropped.
    assign flush_eff = flush | redirect;
    assign accept_fetch = ~flush_eff & ~stall;

    // Jump has priority over branch when both resolve in the same cycle.
    always_comb begin
        redirect_target = branch_target;
        if (jump) begin
            redirect_target = jump_target;
        end
    end

    // Next-PC priority: stall hold, then redirect (word-aligned), then sequential.
    always_comb begin
        pc_next = pc4;
        if (stall) begin
            pc_next = pc_reg;
        end else if (redirect) begin
            pc_next = word_align(redirect_target);
        end
    end

    // Program counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    // Count every real instruction that enters IF/ID; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_reg <= '0;
        end else if (accept_fetch) begin
            fetch_count_reg <= fetch_count_reg + 32'd1;
        end
    end

    // Sticky flag for an accepted redirect whose target was not word aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misaligned_reg <= 1'b0;
        end else if (redirect && (redirect_target[1:0] != 2'b00)) begin
            misaligned_reg <= 1'b1;
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush_eff),
        .stall    (stall),
        .instr_in (imem_rdata),
        .pc4_in   (pc4),
        .instr    (if_id_instr),
        .pc4      (if_id_pc4),
        .valid    (if_id_valid)
    );

    assign pc          = pc_reg;
    assign imem_addr   = pc_reg;
    assign fetch_count = fetch_count_reg;
    assign misaligned  = misaligned_reg;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios then randomized control against a reference model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [31:0] fetch_count;
    logic        misaligned;

    // Second instance with a wrapping reset PC, free-running.
    logic        rst1_n = 1'b0;
    logic        zero1 = 1'b0;
    logic [31:0] zero32 = '0;
    logic [31:0] imem_rdata1;
    logic [31:0] imem_addr1;
    logic [31:0] pc1;
    logic [31:0] if_id_pc4_1;
    logic [31:0] if_id_instr_1;
    logic        if_id_valid_1;
    logic [31:0] fetch_count_1;
    logic        misaligned_1;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pc4, m_count;
    logic        m_valid, m_mis;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h1000_0000 + (addr >> 2);
    endfunction

    assign imem_rdata  = mem_word(imem_addr);
    assign imem_rdata1 = mem_word(imem_addr1);

    if_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .imem_rdata(imem_rdata),
        .imem_addr(imem_addr), .pc(pc), .if_id_pc4(if_id_pc4),
        .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .fetch_count(fetch_count), .misaligned(misaligned)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clk(clk), .rst_n(rst1_n), .stall(zero1), .flush(zero1),
        .branch_taken(zero1), .branch_target(zero32),
        .jump(zero1), .jump_target(zero32), .imem_rdata(imem_rdata1),
        .imem_addr(imem_addr1), .pc(pc1), .if_id_pc4(if_id_pc4_1),
        .if_id_instr(if_id_instr_1), .if_id_valid(if_id_valid_1),
        .fetch_count(fetch_count_1), .misaligned(misaligned_1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".imem_addr"}, imem_addr, m_pc);
        check({tag, ".instr"}, if_id_instr, m_instr);
        check({tag, ".pc4"}, if_id_pc4, m_pc4);
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
        check({tag, ".count"}, fetch_count, m_count);
        check({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, m_mis});
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = '0; m_pc4 = '0; m_valid = 1'b0; m_count = '0; m_mis = 1'b0;
    endtask

    // One clock edge of behaviour, phrased as the pipeline's observable rules.
    task automatic model_edge();
        logic        take;
        logic [31:0] tgt;
        take = !stall && (jump || branch_taken);
        tgt  = jump ? jump_target : branch_target;
        if (take || flush) begin
            m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
        end else if (!stall) begin
            m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            m_count = m_count + 32'd1;
        end
        if (take && (tgt % 4 != 0)) m_mis = 1'b1;
        if (!stall) m_pc = take ? (tgt - (tgt % 4)) : m_pc + 32'd4;
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
        $display("[TB] %s pc=%h instr=%h pc4=%h valid=%0b count=%0d mis=%0b",
                 tag, pc, if_id_instr, if_id_pc4, if_id_valid, fetch_count, misaligned);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_ctrl();
        stall = 0; flush = 0; branch_taken = 0; jump = 0;
        branch_target = '0; jump_target = '0;
    endtask

    initial begin
        logic [31:0] saved;
        model_reset();

        // Reset and free-run
        do_reset("reset");
        tick("run1"); tick("run2"); tick("run3");
        check("plan.pc", pc, 32'h0C);
        check("plan.instr", if_id_instr, 32'h1000_0002);
        check("plan.pc4", if_id_pc4, 32'h0C);
        check("plan.count", fetch_count, 32'd3);

        // Stall two cycles at pc=0x08
        do_reset("reset2");
        tick("pre1"); tick("pre2");
        stall = 1;
        tick("stall1"); tick("stall2");
        check("stall.pc", pc, 32'h08);
        check("stall.count", fetch_count, 32'd2);
        stall = 0;
        tick("release");
        check("release.instr", if_id_instr, 32'h1000_0002);

        // Branch at pc=0x10
        tick("to10");
        check("branch.pre_pc", pc, 32'h10);
        saved = fetch_count;
        branch_taken = 1; branch_target = 32'h40;
        tick("branch");
        check("branch.pc", pc, 32'h40);
        check("branch.valid", {31'd0, if_id_valid}, 32'd0);
        check("branch.count", fetch_count, saved);
        clear_ctrl();
        tick("target");
        check("target.pc4", if_id_pc4, 32'h44);
        check("target.instr", if_id_instr, 32'h1000_0010);

        // Jump beats branch; misaligned jump target
        jump = 1; jump_target = 32'h80; branch_taken = 1; branch_target = 32'h40;
        tick("jump_prio");
        check("jump_prio.pc", pc, 32'h80);
        clear_ctrl();
        jump = 1; jump_target = 32'h82;
        tick("jump_mis");
        check("jump_mis.pc", pc, 32'h80);
        check("jump_mis.flag", {31'd0, misaligned}, 32'd1);
        clear_ctrl();
        tick("sticky1"); tick("sticky2");
        check("sticky.flag", {31'd0, misaligned}, 32'd1);

        // Stall with branch, then stall+flush+branch
        saved = pc;
        stall = 1; branch_taken = 1; branch_target = 32'h200;
        tick("stall_br");
        check("stall_br.pc", pc, saved);
        check("stall_br.valid", {31'd0, if_id_valid}, 32'd1);
        flush = 1;
        tick("stall_flush_br");
        check("stall_flush_br.pc", pc, saved);
        check("stall_flush_br.valid", {31'd0, if_id_valid}, 32'd0);
        clear_ctrl();
        tick("resume");

        // Randomized control against the model
        do_reset("reset3");
        for (int i = 0; i < 400; i++) begin
            stall         = ($urandom_range(0, 4) == 0);
            flush         = ($urandom_range(0, 7) == 0);
            branch_taken  = ($urandom_range(0, 5) == 0);
            jump          = ($urandom_range(0, 9) == 0);
            branch_target = {$urandom_range(0, 255), 2'b00} |
                            (($urandom_range(0, 30) == 0) ? 32'd1 : 32'd0);
            jump_target   = {$urandom_range(0, 255), 2'b00} |
                            (($urandom_range(0, 30) == 0) ? 32'd2 : 32'd0);
            tick($sformatf("rand%0d", i));
        end
        clear_ctrl();

        // Wrapping reset PC and asynchronous mid-cycle reset
        @(negedge clk);
        rst1_n = 1'b1;
        @(posedge clk); #1;
        check("wrap.pc_a", pc1, 32'hFFFF_FFFC);
        check("wrap.instr_a", if_id_instr_1, mem_word(32'hFFFF_FFF8));
        @(posedge clk); #1;
        check("wrap.pc_b", pc1, 32'h0000_0000);
        check("wrap.pc4_b", if_id_pc4_1, 32'h0000_0000);
        check("wrap.valid_b", {31'd0, if_id_valid_1}, 32'd1);
        $display("[TB] wrap pc=%h pc4=%h valid=%0b", pc1, if_id_pc4_1, if_id_valid_1);
        #2;
        rst1_n = 1'b0;
        #1;
        check("async.pc", pc1, 32'hFFFF_FFF8);
        check("async.valid", {31'd0, if_id_valid_1}, 32'd0);
        check("async.count", fetch_count_1, 32'd0);
        $display("[TB] async_reset pc=%h valid=%0b", pc1, if_id_valid_1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
